// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// Single-word backing-memory port; whole-line writeback then refill on a miss.
module dcache_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t                state_q;
    logic [OFF_W-1:0]      cnt_q;
    logic [SETS-1:0]       valid_q;
    logic [SETS-1:0]       dirty_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS][WORDS_PER_LINE];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit, miss, last, unused_ok;

    assign off       = addr_i[OFF_W+1:2];
    assign idx       = addr_i[OFF_W+IDX_W+1:OFF_W+2];
    assign tag       = addr_i[ADDR_WIDTH-1:OFF_W+IDX_W+2];
    assign unused_ok = ^addr_i[1:0];

    assign hit  = (state_q == IDLE) && req_i && valid_q[idx] && (tag_q[idx] == tag);
    assign miss = (state_q == IDLE) && req_i && !hit;
    assign last = (cnt_q == OFF_W'(WORDS_PER_LINE - 1));

    // Reset forces the memory port quiet even while the FSM register still
    // holds a burst state, so an aborted transfer never issues another beat.
    assign stall_o     = rst_i ? req_i : ((state_q != IDLE) || miss);
    assign mem_req_o   = !rst_i && (state_q != IDLE);
    assign mem_we_o    = !rst_i && (state_q == WRITEBACK);
    assign mem_addr_o  = {(state_q == WRITEBACK) ? tag_q[idx] : tag, idx, cnt_q, 2'b00};
    assign mem_wdata_o = data_q[idx][cnt_q];
    assign rdata_o     = data_q[idx][off];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit && we_i) dirty_q[idx] <= 1'b1;
                    if (miss) begin
                        cnt_q   <= '0;
                        state_q <= (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (last) state_q <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        cnt_q <= cnt_q + OFF_W'(1);
                        if (last) begin
                            valid_q[idx] <= 1'b1;
                            dirty_q[idx] <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Data and tag storage carry no reset; validity alone gates their use.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (hit && we_i) data_q[idx][off] <= wdata_i;
            if (state_q == REFILL && mem_ack_i) begin
                data_q[idx][cnt_q] <= mem_rdata_i;
                if (last) tag_q[idx] <= tag;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random traffic
// checked against a flat-memory / line-state reference model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, req_i, we_i, stall_o, mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] addr_i, wdata_i, rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic        s_req, s_we, s_stall, s_mreq, s_mwe, s_mack;
    logic [31:0] s_addr, s_wdata, s_rdata, s_maddr, s_mwdata, s_mrdata;

    dcache_ctrl u_dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    dcache_ctrl #(.SETS(4), .WORDS_PER_LINE(8)) u_small (
        .clk_i(clk), .rst_i(rst_i), .req_i(s_req), .we_i(s_we), .addr_i(s_addr),
        .wdata_i(s_wdata), .rdata_o(s_rdata), .stall_o(s_stall), .mem_req_o(s_mreq),
        .mem_we_o(s_mwe), .mem_addr_o(s_maddr), .mem_wdata_o(s_mwdata),
        .mem_rdata_i(s_mrdata), .mem_ack_i(s_mack)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        bit          v;
        bit          d;
        logic [23:0] tag;
    } line_t;

    txn_t        txn_q[$];
    txn_t        exp_q[$];
    logic [31:0] s_txn_q[$];
    logic [31:0] bmem    [0:1023];
    logic [31:0] ref_mem [0:1023];
    line_t       mline   [16];

    int          vectors = 0;
    int          miscompares = 0;
    int          gap = 0;
    int          wait_n = 0;
    int          hold_err = 0;
    bit          chk_hold = 0;
    logic        prev_req = 0, prev_ack = 0;
    logic [31:0] prev_addr = 0;

    // Backing memory for the main instance: acks after 'gap' idle cycles.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            if (chk_hold && prev_req && !prev_ack &&
                (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr)) hold_err++;
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            if (mem_req_o === 1'b1) begin
                if (wait_n >= gap) begin
                    mem_ack_i = 1'b1;
                    wait_n    = 0;
                    if (mem_we_o) begin
                        bmem[mem_addr_o[11:2]] = mem_wdata_o;
                        txn_q.push_back('{addr: mem_addr_o, we: 1'b1, data: mem_wdata_o});
                    end else begin
                        mem_rdata_i = bmem[mem_addr_o[11:2]];
                        txn_q.push_back('{addr: mem_addr_o, we: 1'b0, data: mem_rdata_i});
                    end
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
            end
            prev_req  = mem_req_o;
            prev_ack  = mem_ack_i;
            prev_addr = mem_addr_o;
        end
    end

    // Backing memory for the small instance: ack every cycle, data derived from address.
    initial begin
        s_mack   = 1'b0;
        s_mrdata = '0;
        forever begin
            @(negedge clk);
            s_mack   = (s_mreq === 1'b1);
            s_mrdata = s_mack ? (s_maddr ^ 32'hA5A5_0000) : $urandom;
            if (s_mack) s_txn_q.push_back(s_maddr);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mline[i] = '{v: 0, d: 0, tag: '0};
        for (int i = 0; i < 1024; i++) ref_mem[i] = bmem[i];
    endtask

    // Core-visible memory semantics plus per-line residency to predict bus traffic.
    task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] exp_rd);
        logic [3:0]  idx;
        logic [23:0] tg;
        logic [31:0] va;
        idx = a[7:4];
        tg  = a[31:8];
        exp_q.delete();
        if (!(mline[idx].v && mline[idx].tag == tg)) begin
            if (mline[idx].v && mline[idx].d)
                for (int w = 0; w < 4; w++) begin
                    va = {mline[idx].tag, idx, 4'(w * 4)};
                    exp_q.push_back('{addr: va, we: 1'b1, data: ref_mem[va[11:2]]});
                end
            for (int w = 0; w < 4; w++)
                exp_q.push_back('{addr: {tg, idx, 4'(w * 4)}, we: 1'b0, data: '0});
            mline[idx] = '{v: 1, d: 0, tag: tg};
        end
        if (we) begin
            ref_mem[a[11:2]] = wd;
            mline[idx].d = 1;
        end
        exp_rd = ref_mem[a[11:2]];
    endtask

    task automatic do_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                             output int stalls, output logic [31:0] rd);
        stalls = 0;
        txn_q.delete();
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd;
        #1;
        while (stall_o === 1'b1 && stalls <= 500) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        rd = rdata_o;
        @(negedge clk);
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            vectors++;
            if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || stall_o !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold req/we/stall got %b%b%b want 000", mem_req_o, mem_we_o, stall_o);
            end
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        vectors++;
        if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_after req/we/stall got %b%b%b want 000", mem_req_o, mem_we_o, stall_o);
        end
        model_reset();
    endtask

    task automatic test_cold_load();
        int stalls; logic [31:0] rd, erd;
        for (int i = 0; i < 4; i++) begin
            bmem[32'h40 + i] = 32'h11 + i;
            ref_mem[32'h40 + i] = 32'h11 + i;
        end
        gap = 0;
        model_access(1'b0, 32'h100, '0, erd);
        do_access(1'b0, 32'h100, '0, stalls, rd);
        vectors++;
        if (stalls != 5) begin miscompares++; $display("FAIL cold_stall got %0d want 5", stalls); end
        vectors++;
        if (rd !== 32'h11) begin miscompares++; $display("FAIL cold_rdata got %h want 00000011", rd); end
        vectors++;
        if (txn_q.size() != 4) begin
            miscompares++; $display("FAIL cold_txn_count got %0d want 4", txn_q.size());
        end else
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (txn_q[i].addr !== 32'h100 + 32'(i * 4) || txn_q[i].we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL cold_txn%0d got %h/%b want %h/0", i, txn_q[i].addr, txn_q[i].we, 32'h100 + 32'(i * 4));
                end
            end
    endtask

    task automatic test_store_hit();
        int stalls; logic [31:0] rd, erd;
        model_access(1'b1, 32'h104, 32'hDEAD, erd);
        do_access(1'b1, 32'h104, 32'hDEAD, stalls, rd);
        vectors++;
        if (stalls != 0 || txn_q.size() != 0) begin
            miscompares++; $display("FAIL store_hit stalls/txns got %0d/%0d want 0/0", stalls, txn_q.size());
        end
        model_access(1'b0, 32'h104, '0, erd);
        do_access(1'b0, 32'h104, '0, stalls, rd);
        vectors++;
        if (stalls != 0) begin miscompares++; $display("FAIL load_hit_stall got %0d want 0", stalls); end
        vectors++;
        if (rd !== 32'hDEAD) begin miscompares++; $display("FAIL load_hit_rdata got %h want 0000dead", rd); end
    endtask

    task automatic test_dirty_evict();
        int stalls; logic [31:0] rd, erd;
        logic [31:0] wb_data [4];
        wb_data = '{32'h11, 32'hDEAD, 32'h13, 32'h14};
        gap = 0;
        model_access(1'b0, 32'h500, '0, erd);
        do_access(1'b0, 32'h500, '0, stalls, rd);
        vectors++;
        if (stalls != 9) begin miscompares++; $display("FAIL evict_stall got %0d want 9", stalls); end
        vectors++;
        if (rd !== erd) begin miscompares++; $display("FAIL evict_rdata got %h want %h", rd, erd); end
        vectors++;
        if (txn_q.size() != 8) begin
            miscompares++; $display("FAIL evict_txn_count got %0d want 8", txn_q.size());
        end else
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (txn_q[i].addr !== 32'h100 + 32'(i * 4) || txn_q[i].we !== 1'b1 || txn_q[i].data !== wb_data[i]) begin
                    miscompares++;
                    $display("FAIL evict_wb%0d got %h/%b/%h want %h/1/%h", i, txn_q[i].addr, txn_q[i].we,
                             txn_q[i].data, 32'h100 + 32'(i * 4), wb_data[i]);
                end
                vectors++;
                if (txn_q[i+4].addr !== 32'h500 + 32'(i * 4) || txn_q[i+4].we !== 1'b0) begin
                    miscompares++;
                    $display("FAIL evict_rd%0d got %h/%b want %h/0", i, txn_q[i+4].addr, txn_q[i+4].we, 32'h500 + 32'(i * 4));
                end
            end
    endtask

    task automatic test_slow_ack();
        int stalls; logic [31:0] rd, erd;
        gap = 3; hold_err = 0; chk_hold = 1;
        model_access(1'b0, 32'h348, '0, erd);
        do_access(1'b0, 32'h348, '0, stalls, rd);
        chk_hold = 0; gap = 0;
        vectors++;
        if (stalls != 17) begin miscompares++; $display("FAIL slow_stall got %0d want 17", stalls); end
        vectors++;
        if (hold_err != 0) begin miscompares++; $display("FAIL slow_hold got %0d want 0 req/addr changes", hold_err); end
        vectors++;
        if (rd !== erd) begin miscompares++; $display("FAIL slow_rdata got %h want %h", rd, erd); end
        vectors++;
        if (txn_q.size() != 4) begin
            miscompares++; $display("FAIL slow_txn_count got %0d want 4", txn_q.size());
        end else
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (txn_q[i].addr !== 32'h340 + 32'(i * 4)) begin
                    miscompares++; $display("FAIL slow_txn%0d got %h want %h", i, txn_q[i].addr, 32'h340 + 32'(i * 4));
                end
            end
    endtask

    task automatic test_reset_mid_burst();
        int stalls, cyc; logic [31:0] rd, erd;
        gap = 1;
        txn_q.delete();
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h2C4;
        cyc = 0;
        while (txn_q.size() < 2 && cyc < 50) begin @(negedge clk); #2; cyc++; end
        vectors++;
        if (txn_q.size() < 2) begin miscompares++; $display("FAIL midrst_acks got %0d want 2", txn_q.size()); end
        @(negedge clk);
        rst_i = 1'b1; req_i = 1'b0;
        #1;
        vectors++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++; $display("FAIL midrst_during req/stall got %b%b want 00", mem_req_o, stall_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        vectors++;
        if (mem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            miscompares++; $display("FAIL midrst_after req/stall got %b%b want 00", mem_req_o, stall_o);
        end
        model_reset();
        model_access(1'b0, 32'h2C4, '0, erd);
        do_access(1'b0, 32'h2C4, '0, stalls, rd);
        gap = 0;
        vectors++;
        if (stalls != 9) begin miscompares++; $display("FAIL midrst_stall got %0d want 9", stalls); end
        vectors++;
        if (rd !== erd) begin miscompares++; $display("FAIL midrst_rdata got %h want %h", rd, erd); end
        vectors++;
        if (txn_q.size() != 4) begin
            miscompares++; $display("FAIL midrst_txn_count got %0d want 4", txn_q.size());
        end else
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (txn_q[i].addr !== 32'h2C0 + 32'(i * 4) || txn_q[i].we !== 1'b0) begin
                    miscompares++; $display("FAIL midrst_txn%0d got %h want %h", i, txn_q[i].addr, 32'h2C0 + 32'(i * 4));
                end
            end
    endtask

    task automatic test_random();
        int stalls, exp_stall; logic [31:0] rd, erd, a, wd; logic we;
        for (int n = 0; n < 200; n++) begin
            gap = $urandom_range(0, 2);
            we  = 1'($urandom_range(0, 1));
            a   = {20'd0, 2'($urandom_range(0, 3)), 2'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
            wd  = $urandom;
            model_access(we, a, wd, erd);
            exp_stall = (exp_q.size() == 0) ? 0 : exp_q.size() * (gap + 1) + 1;
            do_access(we, a, wd, stalls, rd);
            vectors++;
            if (stalls != exp_stall) begin
                miscompares++; $display("FAIL rand%0d_stall addr %h got %0d want %0d", n, a, stalls, exp_stall);
            end
            if (!we) begin
                vectors++;
                if (rd !== erd) begin miscompares++; $display("FAIL rand%0d_rdata addr %h got %h want %h", n, a, rd, erd); end
            end
            vectors++;
            if (txn_q.size() != exp_q.size()) begin
                miscompares++; $display("FAIL rand%0d_txn_count got %0d want %0d", n, txn_q.size(), exp_q.size());
            end else
                for (int i = 0; i < exp_q.size(); i++) begin
                    vectors++;
                    if (txn_q[i].addr !== exp_q[i].addr || txn_q[i].we !== exp_q[i].we ||
                        (exp_q[i].we && txn_q[i].data !== exp_q[i].data)) begin
                        miscompares++;
                        $display("FAIL rand%0d_txn%0d got %h/%b/%h want %h/%b/%h", n, i, txn_q[i].addr, txn_q[i].we,
                                 txn_q[i].data, exp_q[i].addr, exp_q[i].we, exp_q[i].data);
                    end
                end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        gap = 0;
    endtask

    task automatic test_small_cfg();
        int stalls;
        s_txn_q.delete();
        @(negedge clk);
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h40;
        #1;
        stalls = 0;
        while (s_stall === 1'b1 && stalls <= 100) begin stalls++; @(negedge clk); #1; end
        vectors++;
        if (stalls != 9) begin miscompares++; $display("FAIL small_stall got %0d want 9", stalls); end
        vectors++;
        if (s_rdata !== (32'h40 ^ 32'hA5A5_0000)) begin
            miscompares++; $display("FAIL small_rdata got %h want %h", s_rdata, 32'h40 ^ 32'hA5A5_0000);
        end
        vectors++;
        if (s_txn_q.size() != 8) begin
            miscompares++; $display("FAIL small_txn_count got %0d want 8", s_txn_q.size());
        end else
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (s_txn_q[i] !== 32'h40 + 32'(i * 4)) begin
                    miscompares++; $display("FAIL small_txn%0d got %h want %h", i, s_txn_q[i], 32'h40 + 32'(i * 4));
                end
            end
        @(negedge clk);
        s_addr = 32'h5C;
        #1;
        vectors++;
        if (s_stall !== 1'b0 || s_rdata !== (32'h5C ^ 32'hA5A5_0000)) begin
            miscompares++; $display("FAIL small_hit stall/rdata got %b/%h want 0/%h", s_stall, s_rdata, 32'h5C ^ 32'hA5A5_0000);
        end
        s_txn_q.delete();
        @(negedge clk);
        s_addr = 32'h80;
        #1;
        stalls = 0;
        while (s_stall === 1'b1 && stalls <= 100) begin stalls++; @(negedge clk); #1; end
        vectors++;
        if (stalls != 9 || s_txn_q.size() == 0 || s_txn_q[0] !== 32'h80) begin
            miscompares++;
            $display("FAIL small_wrap stalls/first got %0d/%h want 9/00000080", stalls,
                     (s_txn_q.size() != 0) ? s_txn_q[0] : 32'hFFFF_FFFF);
        end
        @(negedge clk);
        s_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) bmem[i] = $urandom;
        test_reset();
        test_cold_load();
        test_store_hit();
        test_dirty_evict();
        test_slow_ack();
        test_reset_mid_burst();
        test_random();
        test_small_cfg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 DATA_WIDTH, 32: width of one data word; fixed at 32 for RV32I.
REQ-002 ADDR_WIDTH, 32: width of the byte address.
REQ-003 SETS, 16: number of direct-mapped lines; a power of two, at least 2.
REQ-004 WORDS_PER_LINE, 4: words per line; a power of two, at least 2.
REQ-005 clk_i  in  1  the single clock; every state element updates on its rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 req_i  in  1  core access request, valid in the same cycle as the address.
REQ-008 we_i  in  1  core write enable; 1 = store, 0 = load.
REQ-009 addr_i  in  ADDR_WIDTH  byte address; bits [1:0] are ignored (word access only).
REQ-010 wdata_i  in  DATA_WIDTH  store data.
REQ-011 rdata_o  out  DATA_WIDTH  load data; combinational from the array on a hit.
REQ-012 stall_o  out  1  core must hold req_i, we_i, addr_i and wdata_i stable while this is 1.
REQ-013 mem_req_o  out  1  backing-memory word request.
REQ-014 mem_we_o  out  1  backing-memory write (writeback).
REQ-015 mem_addr_o  out  ADDR_WIDTH  word-aligned backing-memory byte address.
REQ-016 mem_wdata_o  out  DATA_WIDTH  writeback data.
REQ-017 mem_rdata_i  in  DATA_WIDTH  refill data; valid in the cycle mem_ack_i is 1.
REQ-018 mem_ack_i  in  1  completes one word transfer; may arrive any number of cycles (including zero) after mem_req_o rises.

Function
REQ-019 Address split: offset = addr[log2(WORDS_PER_LINE)+1:2], index = the next log2(SETS) bits, tag = the remaining upper bits.
REQ-020 Each line holds valid, dirty, tag and WORDS_PER_LINE data words; the policy is write-back, write-allocate.
REQ-021 Hit = req_i & valid[index] & (tag[index] == addr tag), evaluated only in IDLE.
REQ-022 Load hit: rdata_o = the addressed word and stall_o = 0 in the same cycle.
REQ-023 Store hit: the word is written and dirty[index] is set at the clock edge; stall_o = 0.
REQ-024 Miss (req_i & !hit in IDLE): stall_o = 1 combinationally in the same cycle.
REQ-025 FSM states are IDLE, WRITEBACK and REFILL; stall_o = 1 in every state except IDLE-with-hit and IDLE-without-req.
REQ-026 IDLE on a miss: go to WRITEBACK if the victim is valid and dirty, otherwise to REFILL; the word counter is cleared to 0.
REQ-027 WRITEBACK: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, counter, 2'b00}, mem_wdata_o = victim word[counter].
REQ-028 WRITEBACK: each mem_ack_i increments the counter; the ack on the last word clears the counter and moves the FSM to REFILL.
REQ-029 REFILL: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {new tag, index, counter, 2'b00}.
REQ-030 REFILL: each mem_ack_i writes mem_rdata_i into word[counter] and increments the counter.
REQ-031 REFILL, ack on the last word: set valid = 1, write the new tag, clear dirty, go to IDLE.
REQ-032 After a refill the held request hits in IDLE on the following cycle and completes per REQ-022/023.
REQ-033 Miss latency: clean miss = WORDS_PER_LINE acks + 1 cycle; dirty miss = 2 x WORDS_PER_LINE acks + 1 cycle.
REQ-034 The word counter is log2(WORDS_PER_LINE) bits wide and wraps to 0 after the last word.
REQ-035 mem_req_o stays 1 between acks inside a burst; mem_req_o = 0 in IDLE.
REQ-036 req_i = 0 in IDLE: no state change and stall_o = 0.
REQ-037 mem_ack_i in IDLE is ignored.
REQ-038 rdata_o is don't-care whenever stall_o = 1 or req_i = 0.

Reset
REQ-039 On rst_i = 1 at a clock edge: FSM = IDLE, counter = 0, and all valid and dirty bits are cleared; data and tag arrays are not reset.
REQ-040 During reset and in the first cycle after it: mem_req_o = 0, mem_we_o = 0, and stall_o = 0 if req_i = 0.
REQ-041 Reset asserted mid-burst aborts the transfer with no partial-line valid; dirty data in flight is lost.

Verification
REQ-042 Cold load at 0x100, memory words 0x11..0x14 with ack every cycle -> 4 read requests to 0x100/0x104/0x108/0x10C, stall_o for 5 cycles, rdata_o = 0x11.
REQ-043 Store 0xDEAD to 0x104 after REQ-042, then load 0x104 -> no stall on either access, rdata_o = 0xDEAD, dirty[0] = 1.
REQ-044 Load 0x500 after REQ-043 (same index 0, new tag) -> 4 writes 0x100..0x10C carrying 0x11, 0xDEAD, 0x13, 0x14, then 4 reads from 0x500.
REQ-045 Refill with acks arriving 3 cycles apart -> mem_req_o held high, mem_addr_o steady between acks, correct word order.
REQ-046 rst_i asserted after the 2nd refill ack, then load the same address -> the full 4-word refill is reissued from the offset-0 address.
REQ-047 SETS = 4, WORDS_PER_LINE = 8 build: cold load 0x40 -> 8 reads 0x40..0x5C, counter wraps to 0, line valid.
